// File: rtl/stdp_update_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : stdp_update_sched_if
// Description : Bundle of spike inputs, learning control, host weight-write
//               port, weight readout and update-report outputs for the STDP
//               update scheduler.
//               master : drives spikes, learn_en, cfg_*, rd_addr
//               slave  : drives weight_out, update_w_flag, upd_*, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface stdp_update_sched_if #(
    parameter int NUM_PRE = 5,
    parameter int TW      = 8,
    parameter int WW      = 8
);
    localparam int CW = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1;

    logic [NUM_PRE-1:0] pre_spike;
    logic               post_spike;
    logic               learn_en;
    logic               cfg_we;
    logic [CW-1:0]      cfg_addr;
    logic [WW-1:0]      cfg_wdata;
    logic [CW-1:0]      rd_addr;
    logic [WW-1:0]      weight_out;
    logic               update_w_flag;
    logic [CW-1:0]      upd_chan;
    logic [TW-1:0]      upd_dt;
    logic               upd_ltd;
    logic               busy;

    modport master (
        output pre_spike, post_spike, learn_en, cfg_we, cfg_addr, cfg_wdata, rd_addr,
        input  weight_out, update_w_flag, upd_chan, upd_dt, upd_ltd, busy
    );

    modport slave (
        input  pre_spike, post_spike, learn_en, cfg_we, cfg_addr, cfg_wdata, rd_addr,
        output weight_out, update_w_flag, upd_chan, upd_dt, upd_ltd, busy
    );
endinterface
`default_nettype wire

// File: rtl/stdp_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : stdp_update_sched
// Description : STDP learning-rule scheduler. Timestamps pre/post spikes,
//               detects causal (LTP) and anti-causal (LTD) pairs inside the
//               pairing window, queues one pending update per channel and
//               direction, and serialises them round-robin through a single
//               IDLE -> CALC -> WRITE weight-update datapath.
// Ports       : clk, rst (sync, active high)
//               bus (slave) : spike inputs, learn_en, cfg write port,
//                             rd_addr/weight_out readout, update report, busy
// Revision    : 1.0 - initial release
// ============================================================================
module stdp_update_sched #(
    parameter int NUM_PRE = 5,
    parameter int TW      = 8,
    parameter int WW      = 8,
    parameter int WINDOW  = 16,
    parameter int W_INIT  = 8,
    parameter int W_MAX   = 255
) (
    input wire                 clk,
    input wire                 rst,
    stdp_update_sched_if.slave bus
);
    localparam int            CW       = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1;
    localparam logic [TW-1:0] c_window = TW'(WINDOW);
    localparam logic [WW:0]   c_w_max  = (WW+1)'(W_MAX);
    localparam logic [WW-1:0] c_w_init = WW'(W_INIT);
    localparam logic [CW-1:0] c_last   = CW'(NUM_PRE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [TW-1:0]      r_pre_t  [NUM_PRE];
    logic [TW-1:0]      r_dt_ltp [NUM_PRE];
    logic [TW-1:0]      r_dt_ltd [NUM_PRE];
    logic [WW-1:0]      r_weight [NUM_PRE];
    logic [TW-1:0]      r_post_t;
    logic [NUM_PRE-1:0] r_ltp_pend, r_ltd_pend;
    logic [NUM_PRE-1:0] w_ltp_det, w_ltd_det, w_ltp_clr, w_ltd_clr;
    logic [CW-1:0]      r_rr_ptr, r_chan, r_upd_chan;
    logic [TW-1:0]      r_dt, r_upd_dt;
    logic               r_ltd, r_upd_ltd, r_flag;
    logic [WW:0]        r_delta;
    logic [WW-1:0]      r_wcur;
    logic               w_found, w_sel_ltd, w_take, w_cfg_hit;
    logic [CW-1:0]      w_sel_chan, w_idx;
    logic [TW:0]        w_span, w_delta_tw;
    logic [WW:0]        w_delta_ext, w_sum, w_dif;
    logic [WW-1:0]      w_new_w;

    // Pair detection uses the timers as they stood before this edge. A
    // simultaneous pre/post on one channel is treated as LTP only.
    generate
        for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_detect
            assign w_ltp_det[gi] = bus.post_spike & bus.learn_en & (r_pre_t[gi] < c_window);
            assign w_ltd_det[gi] = bus.pre_spike[gi] & bus.learn_en & ~bus.post_spike
                                 & (r_post_t < c_window);
        end
    endgenerate

    // Round-robin search from r_rr_ptr; LTP wins over LTD on the same channel.
    always_comb begin
        w_found    = 1'b0;
        w_sel_chan = '0;
        w_sel_ltd  = 1'b0;
        w_idx      = r_rr_ptr;
        for (int k = 0; k < NUM_PRE; k++) begin
            if (!w_found && (r_ltp_pend[w_idx] || r_ltd_pend[w_idx])) begin
                w_found    = 1'b1;
                w_sel_chan = w_idx;
                w_sel_ltd  = ~r_ltp_pend[w_idx];
            end
            w_idx = (w_idx == c_last) ? '0 : w_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_ltp_clr   = '0;
        w_ltd_clr   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_CALC;
                    if (w_sel_ltd) w_ltd_clr[w_sel_chan] = 1'b1;
                    else           w_ltp_clr[w_sel_chan] = 1'b1;
                end
            end
            ST_CALC:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Timers saturate at all-ones. A detection in the same cycle as the
    // scheduler clears a pending bit wins, so the update is re-queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_post_t   <= '1;
            r_ltp_pend <= '0;
            r_ltd_pend <= '0;
            for (int i = 0; i < NUM_PRE; i++) begin
                r_pre_t[i]  <= '1;
                r_dt_ltp[i] <= '0;
                r_dt_ltd[i] <= '0;
            end
        end else begin
            r_post_t   <= bus.post_spike ? '0 : ((r_post_t == '1) ? r_post_t : r_post_t + 1'b1);
            r_ltp_pend <= w_ltp_det | (r_ltp_pend & ~w_ltp_clr);
            r_ltd_pend <= w_ltd_det | (r_ltd_pend & ~w_ltd_clr);
            for (int i = 0; i < NUM_PRE; i++) begin
                r_pre_t[i] <= bus.pre_spike[i] ? '0
                            : ((r_pre_t[i] == '1) ? r_pre_t[i] : r_pre_t[i] + 1'b1);
                if (w_ltp_det[i]) r_dt_ltp[i] <= r_pre_t[i];
                if (w_ltd_det[i]) r_dt_ltd[i] <= r_post_t;
            end
        end
    end

    // delta = ((WINDOW - dt) + 1) >> 1 in TW+1 bits, then widened to WW+1.
    assign w_span     = (TW+1)'(WINDOW) - {1'b0, r_dt} + (TW+1)'(1);
    assign w_delta_tw = w_span >> 1;

    generate
        if (TW == WW) begin : g_ext_eq
            assign w_delta_ext = w_delta_tw;
        end else if (TW < WW) begin : g_ext_pad
            assign w_delta_ext = {{(WW-TW){1'b0}}, w_delta_tw};
        end else begin : g_ext_trunc
            assign w_delta_ext = w_delta_tw[WW:0];
        end
    endgenerate

    // Saturating update; a borrow out of the WW+1 difference means below zero.
    assign w_sum   = {1'b0, r_wcur} + r_delta;
    assign w_dif   = {1'b0, r_wcur} - r_delta;
    assign w_new_w = r_ltd ? (w_dif[WW] ? '0 : w_dif[WW-1:0])
                           : ((w_sum > c_w_max) ? c_w_max[WW-1:0] : w_sum[WW-1:0]);

    // Host write to the channel being committed drops the scheduled update.
    assign w_cfg_hit = bus.cfg_we && (bus.cfg_addr == r_chan);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_chan     <= '0;
            r_dt       <= '0;
            r_ltd      <= 1'b0;
            r_delta    <= '0;
            r_wcur     <= '0;
            r_flag     <= 1'b0;
            r_upd_chan <= '0;
            r_upd_dt   <= '0;
            r_upd_ltd  <= 1'b0;
            for (int i = 0; i < NUM_PRE; i++) r_weight[i] <= c_w_init;
        end else begin
            r_flag <= 1'b0;
            if (w_take) begin
                r_chan <= w_sel_chan;
                r_dt   <= w_sel_ltd ? r_dt_ltd[w_sel_chan] : r_dt_ltp[w_sel_chan];
                r_ltd  <= w_sel_ltd;
            end
            if (r_state == ST_CALC) begin
                r_delta <= w_delta_ext;
                r_wcur  <= r_weight[r_chan];
            end
            if (r_state == ST_WRITE) begin
                r_rr_ptr <= (r_chan == c_last) ? '0 : r_chan + 1'b1;
                if (!w_cfg_hit) begin
                    r_weight[r_chan] <= w_new_w;
                    r_flag           <= 1'b1;
                    r_upd_chan       <= r_chan;
                    r_upd_dt         <= r_dt;
                    r_upd_ltd        <= r_ltd;
                end
            end
            if (bus.cfg_we && (int'(bus.cfg_addr) < NUM_PRE))
                r_weight[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    assign bus.weight_out    = (int'(bus.rd_addr) < NUM_PRE) ? r_weight[bus.rd_addr] : '0;
    assign bus.update_w_flag = r_flag;
    assign bus.upd_chan      = r_upd_chan;
    assign bus.upd_dt        = r_upd_dt;
    assign bus.upd_ltd       = r_upd_ltd;
    assign bus.busy          = (r_state != ST_IDLE) | (|r_ltp_pend) | (|r_ltd_pend);

endmodule
`default_nettype wire

// File: tb/tb_stdp_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_stdp_update_sched
// Description : Self-checking bench for stdp_update_sched. Expected updates
//               are queued as stimulus is applied and compared against each
//               update_w_flag pulse; scenario tasks check timing and weights.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stdp_update_sched;
    localparam int NUM_PRE = 5;
    localparam int TW      = 8;
    localparam int WW      = 8;

    typedef struct packed {
        logic [2:0] chan;
        logic [7:0] dt;
        logic       ltd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_exp;

    always #5 clk = ~clk;

    stdp_update_sched_if #(.NUM_PRE(NUM_PRE), .TW(TW), .WW(WW)) bus ();

    stdp_update_sched #(
        .NUM_PRE(NUM_PRE), .TW(TW), .WW(WW),
        .WINDOW(16), .W_INIT(8), .W_MAX(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Scoreboard: every committed update must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.update_w_flag === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got update chan=%0d dt=%0d ltd=%0d, required none",
                         bus.upd_chan, bus.upd_dt, bus.upd_ltd);
            end else begin
                mon_exp = sb_q.pop_front();
                if (bus.upd_chan !== mon_exp.chan || bus.upd_dt !== mon_exp.dt ||
                    bus.upd_ltd !== mon_exp.ltd) begin
                    errors++;
                    $display("FAIL sb_update: got chan=%0d dt=%0d ltd=%0d, required chan=%0d dt=%0d ltd=%0d",
                             bus.upd_chan, bus.upd_dt, bus.upd_ltd,
                             mon_exp.chan, mon_exp.dt, mon_exp.ltd);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spike(input logic [NUM_PRE-1:0] pre, input logic post);
        bus.pre_spike  = pre;
        bus.post_spike = post;
        step(1);
        bus.pre_spike  = '0;
        bus.post_spike = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.busy) && n < 80) begin
            step(1);
            n++;
        end
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (bus.update_w_flag !== 1'b0) begin errors++; $display("FAIL rst_flag: got %0b, required 0", bus.update_w_flag); end
        if (bus.upd_chan !== 3'd0) begin errors++; $display("FAIL rst_upd_chan: got %0d, required 0", bus.upd_chan); end
        if (bus.upd_dt !== 8'd0) begin errors++; $display("FAIL rst_upd_dt: got %0d, required 0", bus.upd_dt); end
        if (bus.upd_ltd !== 1'b0) begin errors++; $display("FAIL rst_upd_ltd: got %0b, required 0", bus.upd_ltd); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, required 0", bus.busy); end
        for (int i = 0; i < NUM_PRE; i++) begin
            bus.rd_addr = 3'(i);
            #1;
            checks++;
            if (bus.weight_out !== 8'd8) begin
                errors++;
                $display("FAIL rst_weight[%0d]: got %0d, required 8", i, bus.weight_out);
            end
        end
    endtask

    task automatic test_causal();
        do_reset();
        spike(5'b00001, 1'b0);                 // edge 0
        step(2);                               // edges 1,2
        sb_q.push_back('{chan: 3'd0, dt: 8'd2, ltd: 1'b0});
        spike(5'b00000, 1'b1);                 // edge 3, pre_t[0]=2
        step(2);                               // after edge 5
        checks += 2;
        if (bus.update_w_flag !== 1'b0) begin errors++; $display("FAIL causal_flag_early: got %0b, required 0", bus.update_w_flag); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL causal_busy: got %0b, required 1", bus.busy); end
        step(1);                               // after edge 6
        checks++;
        if (bus.update_w_flag !== 1'b1) begin errors++; $display("FAIL causal_flag_t3: got %0b, required 1", bus.update_w_flag); end
        step(1);
        checks++;
        if (bus.update_w_flag !== 1'b0) begin errors++; $display("FAIL causal_flag_pulse: got %0b, required 0", bus.update_w_flag); end
        wait_drain();
        bus.rd_addr = 3'd0;
        #1;
        checks += 2;
        if (sb_q.size() != 0) begin errors++; $display("FAIL causal_drain: got %0d pending, required 0", sb_q.size()); end
        if (bus.weight_out !== 8'd15) begin errors++; $display("FAIL causal_weight: got %0d, required 15", bus.weight_out); end
    endtask

    task automatic test_anticausal();
        do_reset();
        sb_q.push_back('{chan: 3'd1, dt: 8'd4, ltd: 1'b1});
        spike(5'b00000, 1'b1);                 // edge 0
        step(4);                               // edges 1..4
        spike(5'b00010, 1'b0);                 // edge 5, post_t=4
        wait_drain();
        bus.rd_addr = 3'd1;
        #1;
        checks += 4;
        if (sb_q.size() != 0) begin errors++; $display("FAIL anti_drain: got %0d pending, required 0", sb_q.size()); end
        if (bus.weight_out !== 8'd2) begin errors++; $display("FAIL anti_weight: got %0d, required 2", bus.weight_out); end
        if (bus.upd_dt !== 8'd4) begin errors++; $display("FAIL anti_hold_dt: got %0d, required 4", bus.upd_dt); end
        if (bus.upd_ltd !== 1'b1) begin errors++; $display("FAIL anti_hold_ltd: got %0b, required 1", bus.upd_ltd); end
    endtask

    task automatic test_sat_ltp();
        do_reset();
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_wdata = 8'd250;
        step(1);
        bus.cfg_we = 1'b0;
        bus.rd_addr = 3'd2;
        #1;
        checks++;
        if (bus.weight_out !== 8'd250) begin errors++; $display("FAIL cfg_write: got %0d, required 250", bus.weight_out); end
        sb_q.push_back('{chan: 3'd2, dt: 8'd0, ltd: 1'b0});
        spike(5'b00100, 1'b0);
        spike(5'b00000, 1'b1);
        wait_drain();
        checks += 2;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sat_ltp_drain: got %0d pending, required 0", sb_q.size()); end
        if (bus.weight_out !== 8'd255) begin errors++; $display("FAIL sat_ltp_weight: got %0d, required 255", bus.weight_out); end
    endtask

    task automatic test_sat_ltd();
        do_reset();
        bus.rd_addr = 3'd3;
        for (int r = 0; r < 2; r++) begin
            sb_q.push_back('{chan: 3'd3, dt: 8'd0, ltd: 1'b1});
            spike(5'b00000, 1'b1);
            spike(5'b01000, 1'b0);
            wait_drain();
            checks += 2;
            if (sb_q.size() != 0) begin errors++; $display("FAIL sat_ltd_drain%0d: got %0d pending, required 0", r, sb_q.size()); end
            if (bus.weight_out !== 8'd0) begin errors++; $display("FAIL sat_ltd_weight%0d: got %0d, required 0", r, bus.weight_out); end
            step(20);                          // let pre_t[3] leave the window
        end
    endtask

    task automatic test_fanout_rr();
        logic exp_flag;
        do_reset();
        sb_q.push_back('{chan: 3'd0, dt: 8'd0, ltd: 1'b0});
        sb_q.push_back('{chan: 3'd1, dt: 8'd0, ltd: 1'b0});
        sb_q.push_back('{chan: 3'd4, dt: 8'd0, ltd: 1'b0});
        spike(5'b10011, 1'b0);                 // edge 0
        spike(5'b00000, 1'b1);                 // edge 1
        for (int e = 2; e <= 10; e++) begin
            step(1);
            exp_flag = (e == 4 || e == 7 || e == 10);
            checks++;
            if (bus.update_w_flag !== exp_flag) begin
                errors++;
                $display("FAIL rr_flag_edge%0d: got %0b, required %0b", e, bus.update_w_flag, exp_flag);
            end
        end
        wait_drain();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d pending, required 0", sb_q.size()); end
        for (int c = 0; c < NUM_PRE; c++) begin
            bus.rd_addr = 3'(c);
            #1;
            checks++;
            if (bus.weight_out !== ((c == 2 || c == 3) ? 8'd8 : 8'd16)) begin
                errors++;
                $display("FAIL rr_weight[%0d]: got %0d, required %0d", c, bus.weight_out,
                         (c == 2 || c == 3) ? 8 : 16);
            end
        end
    endtask

    task automatic test_window_edge();
        do_reset();
        sb_q.push_back('{chan: 3'd0, dt: 8'd15, ltd: 1'b0});
        spike(5'b00001, 1'b0);                 // edge 0
        step(15);
        spike(5'b00000, 1'b1);                 // edge 16, pre_t=15
        wait_drain();
        bus.rd_addr = 3'd0;
        #1;
        checks += 2;
        if (sb_q.size() != 0) begin errors++; $display("FAIL win_in_drain: got %0d pending, required 0", sb_q.size()); end
        if (bus.weight_out !== 8'd9) begin errors++; $display("FAIL win_in_weight: got %0d, required 9", bus.weight_out); end
        do_reset();
        spike(5'b00001, 1'b0);                 // edge 0
        step(16);
        spike(5'b00000, 1'b1);                 // edge 17, pre_t=16
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.update_w_flag !== 1'b0) begin
                errors++;
                $display("FAIL win_out_idle%0d: got busy=%0b flag=%0b, required 0/0", k, bus.busy, bus.update_w_flag);
            end
            step(1);
        end
        checks++;
        if (bus.weight_out !== 8'd8) begin errors++; $display("FAIL win_out_weight: got %0d, required 8", bus.weight_out); end
    endtask

    task automatic test_learn_disable();
        do_reset();
        bus.learn_en = 1'b0;
        spike(5'b00001, 1'b0);
        spike(5'b00000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.update_w_flag !== 1'b0) begin
                errors++;
                $display("FAIL learn_off%0d: got busy=%0b flag=%0b, required 0/0", k, bus.busy, bus.update_w_flag);
            end
            step(1);
        end
        bus.learn_en = 1'b1;
        bus.rd_addr  = 3'd0;
        #1;
        checks++;
        if (bus.weight_out !== 8'd8) begin errors++; $display("FAIL learn_off_weight: got %0d, required 8", bus.weight_out); end
    endtask

    task automatic test_reset_in_calc();
        do_reset();
        spike(5'b00001, 1'b0);                 // edge 0
        spike(5'b00000, 1'b1);                 // edge 1, pending set
        step(1);                               // edge 2, now in CALC
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL calc_busy: got %0b, required 1", bus.busy); end
        rst = 1'b1;
        step(1);                               // edge 3 with reset
        bus.rd_addr = 3'd0;
        #1;
        checks += 6;
        if (bus.weight_out !== 8'd8) begin errors++; $display("FAIL calc_rst_weight: got %0d, required 8", bus.weight_out); end
        if (bus.update_w_flag !== 1'b0) begin errors++; $display("FAIL calc_rst_flag: got %0b, required 0", bus.update_w_flag); end
        if (bus.upd_chan !== 3'd0) begin errors++; $display("FAIL calc_rst_chan: got %0d, required 0", bus.upd_chan); end
        if (bus.upd_dt !== 8'd0) begin errors++; $display("FAIL calc_rst_dt: got %0d, required 0", bus.upd_dt); end
        if (bus.upd_ltd !== 1'b0) begin errors++; $display("FAIL calc_rst_ltd: got %0b, required 0", bus.upd_ltd); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL calc_rst_busy: got %0b, required 0", bus.busy); end
        rst = 1'b0;
        step(6);
        checks++;
        if (bus.weight_out !== 8'd8) begin errors++; $display("FAIL calc_post_weight: got %0d, required 8", bus.weight_out); end
    endtask

    task automatic test_cfg_collision();
        do_reset();
        spike(5'b00001, 1'b0);                 // edge 0
        spike(5'b00000, 1'b1);                 // edge 1
        step(2);                               // edges 2,3
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_wdata = 8'd100;
        step(1);                               // edge 4 = WRITE edge
        bus.cfg_we = 1'b0;
        bus.rd_addr = 3'd0;
        #1;
        checks += 2;
        if (bus.update_w_flag !== 1'b0) begin errors++; $display("FAIL coll_flag: got %0b, required 0", bus.update_w_flag); end
        if (bus.weight_out !== 8'd100) begin errors++; $display("FAIL coll_weight: got %0d, required 100", bus.weight_out); end
        step(3);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL coll_busy: got %0b, required 0", bus.busy); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.pre_spike = '0;
        bus.post_spike = 1'b0;
        bus.learn_en  = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.rd_addr   = '0;
        test_reset();
        test_causal();
        test_anticausal();
        test_sat_ltp();
        test_sat_ltd();
        test_fanout_rr();
        test_window_edge();
        test_learn_disable();
        test_reset_in_calc();
        test_cfg_collision();
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
